// File: rtl/mpa_pkg.sv
// mpa_pkg
// Shared definitions for the multi-precision arithmetic sequencer:
//   - operation codes carried on the op input
//   - carry-in select codes driven on sci toward the ALU carry-in mux
//   - sequencer FSM state encoding
//   - bit positions of C/Z/S/V inside the flag_in load vector
//   - small decode helpers for the first-word carry-in and subtract control
package mpa_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } op_e;

    localparam logic [1:0] SCI_ZERO  = 2'b00;
    localparam logic [1:0] SCI_ONE   = 2'b01;
    localparam logic [1:0] SCI_FLAGC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int NUM_FLAGS  = 4;
    localparam int FLAG_C_BIT = 3;
    localparam int FLAG_Z_BIT = 2;
    localparam int FLAG_S_BIT = 1;
    localparam int FLAG_V_BIT = 0;

    // Carry-in for the least-significant word. SUB forces 1 because the ALU
    // computes A + ~B + cin; ADC/SBB chain in the architectural carry, where
    // C means "no borrow" for subtraction.
    function automatic logic [1:0] first_sci(input logic [1:0] op);
        logic [1:0] code;
        case (op)
            OP_ADD:  code = SCI_ZERO;
            OP_SUB:  code = SCI_ONE;
            default: code = SCI_FLAGC;
        endcase
        return code;
    endfunction

    function automatic logic is_sub(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

endpackage

// File: rtl/mpa_flag_reg.sv
// mpa_flag_reg
// Architectural C/Z/S/V flag register for the multi-precision sequencer.
// Ports:
//   clk, reset        clock and asynchronous active-low reset (flags -> 0)
//   load_en, load_val direct load of {C,Z,S,V} (highest priority)
//   word_en           a word was processed this cycle: capture carry only
//   last_en           that word was the last one: also capture Z, S, V
//   c_val..v_val      values captured on word_en / last_en
//   flag_c..flag_v    registered flag outputs
module mpa_flag_reg
    import mpa_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic [NUM_FLAGS-1:0] load_val,
    input  logic                 word_en,
    input  logic                 last_en,
    input  logic                 c_val,
    input  logic                 z_val,
    input  logic                 s_val,
    input  logic                 v_val,
    output logic                 flag_c,
    output logic                 flag_z,
    output logic                 flag_s,
    output logic                 flag_v
);

    // Load wins over any arithmetic update. Every processed word refreshes C
    // so the next word's chained carry sees it; Z/S/V describe the whole
    // multi-word result and therefore only change on the last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_s <= 1'b0;
            flag_v <= 1'b0;
        end else if (load_en) begin
            flag_c <= load_val[FLAG_C_BIT];
            flag_z <= load_val[FLAG_Z_BIT];
            flag_s <= load_val[FLAG_S_BIT];
            flag_v <= load_val[FLAG_V_BIT];
        end else if (word_en) begin
            flag_c <= c_val;
            if (last_en) begin
                flag_z <= z_val;
                flag_s <= s_val;
                flag_v <= v_val;
            end
        end
    end

endmodule

// File: rtl/mpa_seq.sv
// mpa_seq
// Multi-precision arithmetic sequencer. Steps the ALU through ADD/SUB/ADC/SBB
// over 1..2**IDX_W words, least-significant word first, one word per cycle,
// and owns the architectural C/Z/S/V flags.
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   start, op, nwords     request, operation and (word count - 1), taken in IDLE
//   flag_load, flag_in    load {C,Z,S,V}, honoured only in IDLE
//   alu_cout/zero/sign/ovf  ALU status for the current word
//   sci                   carry-in select: 00 zero, 01 one, 10 flag_c
//   alu_sub               ALU inverts B (SUB/SBB)
//   word_idx, wr_en       operand/result word address and write strobe
//   busy, done            activity indicator and one-cycle completion pulse
//   flag_c/z/s/v          registered flags; flag_c feeds the carry-in mux
module mpa_seq
    import mpa_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int IDX_W  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [IDX_W-1:0]     nwords,
    input  logic                 flag_load,
    input  logic [NUM_FLAGS-1:0] flag_in,
    input  logic                 alu_cout,
    input  logic                 alu_zero,
    input  logic                 alu_sign,
    input  logic                 alu_ovf,
    output logic [1:0]           sci,
    output logic                 alu_sub,
    output logic [IDX_W-1:0]     word_idx,
    output logic                 wr_en,
    output logic                 busy,
    output logic                 done,
    output logic                 flag_c,
    output logic                 flag_z,
    output logic                 flag_s,
    output logic                 flag_v
);

    // The flags describe an ALU word of WORD_W bits; there is no datapath
    // here, so the word width only qualifies the flag vector.
    localparam int FLAG_W = (WORD_W > 0) ? NUM_FLAGS : 0;

    state_e           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] last_idx;
    logic             z_acc;

    logic             exec_en;
    logic             last_word;
    logic             load_en;
    logic [FLAG_W-1:0] load_val;

    assign word_idx  = idx;
    assign exec_en   = (state == ST_EXEC);
    assign last_word = exec_en && (idx == last_idx);
    assign load_en   = flag_load && (state == ST_IDLE);
    assign load_val  = flag_in;

    // Sequencer FSM. All ALU-facing controls are registered and set up one
    // cycle ahead, so in each EXEC cycle they already describe the word being
    // processed and no input reaches an output combinationally. The first
    // word gets the op-specific carry-in; every later word chains flag_c,
    // which the flag register has just refreshed from the previous word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            last_idx <= '0;
            z_acc    <= 1'b1;
            sci      <= SCI_ZERO;
            alu_sub  <= 1'b0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_EXEC;
                        idx      <= '0;
                        last_idx <= nwords;
                        z_acc    <= 1'b1;
                        sci      <= first_sci(op);
                        alu_sub  <= is_sub(op);
                        wr_en    <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    idx   <= idx + 1'b1;
                    z_acc <= z_acc & alu_zero;
                    if (last_word) begin
                        state   <= ST_DONE;
                        sci     <= SCI_ZERO;
                        alu_sub <= 1'b0;
                        wr_en   <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        sci <= SCI_FLAGC;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    idx     <= '0;
                    sci     <= SCI_ZERO;
                    alu_sub <= 1'b0;
                    wr_en   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    mpa_flag_reg u_flags (
        .clk      (clk),
        .reset    (reset),
        .load_en  (load_en),
        .load_val (load_val),
        .word_en  (exec_en),
        .last_en  (last_word),
        .c_val    (alu_cout),
        .z_val    (z_acc & alu_zero),
        .s_val    (alu_sign),
        .v_val    (alu_ovf),
        .flag_c   (flag_c),
        .flag_z   (flag_z),
        .flag_s   (flag_s),
        .flag_v   (flag_v)
    );

endmodule

// File: tb/tb_mpa_seq.sv
// tb_mpa_seq
// Scoreboard bench for mpa_seq. A behavioural 16-bit ALU and carry-in mux
// sit around the DUT. Each request pushes its expected per-word controls and
// its expected completion (cycle, full-width result, flags) into queues; the
// expected values come from whole-number arithmetic on the concatenated
// operands. A monitor pops and compares whenever wr_en or done is seen.
module tb_mpa_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op_i;
    logic [1:0]  nwords_i;
    logic        flag_load;
    logic [3:0]  flag_in;
    logic        alu_cout;
    logic        alu_zero;
    logic        alu_sign;
    logic        alu_ovf;
    logic [1:0]  sci;
    logic        alu_sub;
    logic [1:0]  word_idx;
    logic        wr_en;
    logic        busy;
    logic        done;
    logic        flag_c;
    logic        flag_z;
    logic        flag_s;
    logic        flag_v;

    mpa_seq #(.WORD_W(16), .IDX_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op_i),
        .nwords    (nwords_i),
        .flag_load (flag_load),
        .flag_in   (flag_in),
        .alu_cout  (alu_cout),
        .alu_zero  (alu_zero),
        .alu_sign  (alu_sign),
        .alu_ovf   (alu_ovf),
        .sci       (sci),
        .alu_sub   (alu_sub),
        .word_idx  (word_idx),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_s    (flag_s),
        .flag_v    (flag_v)
    );

    typedef struct {
        logic [1:0] idx;
        logic [1:0] sci;
        logic       sub;
    } word_t;

    typedef struct {
        int          cyc;
        int          n;
        logic [79:0] res;
        logic [3:0]  flags;
    } done_t;

    word_t       wq[$];
    done_t       dq[$];
    logic [15:0] a_w[4];
    logic [15:0] b_w[4];
    logic [15:0] res_acc[4];
    logic [3:0]  mflags;
    logic [79:0] last_res;
    logic [3:0]  last_flags;
    int          cyc;
    int          total;
    int          bad;
    bit          mon_en;

    logic        alu_cin;
    logic [15:0] alu_bop;
    logic [16:0] alu_sum;

    // Clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU plus the external carry-in mux.
    always_comb begin
        alu_cin  = 1'b0;
        if (sci == 2'b01) alu_cin = 1'b1;
        if (sci == 2'b10) alu_cin = flag_c;
        alu_bop  = alu_sub ? ~b_w[word_idx] : b_w[word_idx];
        alu_sum  = {1'b0, a_w[word_idx]} + {1'b0, alu_bop} + {16'd0, alu_cin};
        alu_cout = alu_sum[16];
        alu_zero = (alu_sum[15:0] == 16'd0);
        alu_sign = alu_sum[15];
        alu_ovf  = (a_w[word_idx][15] == alu_bop[15]) && (alu_sum[15] != a_w[word_idx][15]);
    end

    task automatic check_output(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the operation on whole (n+1)*16-bit numbers.
    function automatic void model(input logic [1:0] o, input int n, input logic [3:0] fin,
                                  output logic [79:0] r, output logic [3:0] f);
        int          w;
        logic [79:0] a;
        logic [79:0] b;
        logic [79:0] full;
        logic [79:0] mask;
        logic        c;
        logic        borrow;
        logic        sa;
        logic        sb;
        logic        sr;
        logic        v;
        w = 16 * (n + 1);
        a = '0;
        b = '0;
        for (int i = 0; i <= n; i++) begin
            a = a | ({64'd0, a_w[i]} << (16 * i));
            b = b | ({64'd0, b_w[i]} << (16 * i));
        end
        mask = (80'd1 << w) - 80'd1;
        if (o == 2'b00 || o == 2'b10) begin
            full = a + b + ((o == 2'b10) ? {79'd0, fin[3]} : 80'd0);
            c = full[w];
        end else begin
            borrow = (o == 2'b11) ? ~fin[3] : 1'b0;
            c = (a >= b + {79'd0, borrow});
            full = a - b - {79'd0, borrow};
        end
        r  = full & mask;
        sa = a[w-1];
        sb = b[w-1];
        sr = r[w-1];
        if (o == 2'b00 || o == 2'b10) v = (sa == sb) && (sr != sa);
        else v = (sa != sb) && (sr != sa);
        f = {c, (r == 80'd0), sr, v};
    endfunction

    function automatic logic [1:0] exp_first_sci(input logic [1:0] o);
        case (o)
            2'b00:   return 2'b00;
            2'b01:   return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    // Monitor: compares every presented word and every completion.
    word_t       mw;
    done_t       md;
    logic [79:0] mres;
    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (wr_en) begin
                check_output("wr_expected", (wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    mw = wq.pop_front();
                    check_output("word_idx", word_idx, mw.idx);
                    check_output("sci", sci, mw.sci);
                    check_output("alu_sub", alu_sub, mw.sub);
                    check_output("busy_exec", busy, 1);
                    check_output("done_in_exec", done, 0);
                    res_acc[word_idx] = alu_sum[15:0];
                end
            end
            if (done) begin
                check_output("done_expected", (dq.size() > 0), 1);
                if (dq.size() > 0) begin
                    md = dq.pop_front();
                    mres = '0;
                    for (int i = 0; i <= md.n; i++) mres = mres | ({64'd0, res_acc[i]} << (16 * i));
                    check_output("done_cycle", md.cyc, cyc);
                    check_output("result", mres, md.res);
                    check_output("flags", {flag_c, flag_z, flag_s, flag_v}, md.flags);
                    check_output("busy_done", busy, 1);
                    check_output("wr_en_done", wr_en, 0);
                    last_res   = mres;
                    last_flags = {flag_c, flag_z, flag_s, flag_v};
                end
            end
        end
    end

    // One request; operands must already be in a_w/b_w. With poke set, start
    // and flag_load are pulsed during EXEC and start again during DONE.
    task automatic apply_stimulus(input logic [1:0] o, input int n, input logic do_load,
                                  input logic [3:0] lv, input logic poke);
        int          c0;
        logic [79:0] r;
        logic [3:0]  f;
        logic [3:0]  fin;
        word_t       wi;
        done_t       di;
        bit          seen;
        @(posedge clk); #1;
        start     = 1'b1;
        op_i      = o;
        nwords_i  = 2'(n);
        flag_load = do_load;
        flag_in   = lv;
        c0        = cyc;
        fin       = do_load ? lv : mflags;
        model(o, n, fin, r, f);
        for (int i = 0; i <= n; i++) begin
            wi.idx = 2'(i);
            wi.sci = (i == 0) ? exp_first_sci(o) : 2'b10;
            wi.sub = (o == 2'b01) || (o == 2'b11);
            wq.push_back(wi);
        end
        di.cyc   = c0 + 2 + n;
        di.n     = n;
        di.res   = r;
        di.flags = f;
        dq.push_back(di);
        mflags = f;
        @(posedge clk); #1;
        start     = 1'b0;
        flag_load = 1'b0;
        if (poke) begin
            start     = 1'b1;
            flag_load = 1'b1;
            flag_in   = 4'($urandom);
            @(posedge clk); #1;
            start     = 1'b0;
            flag_load = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        check_output("done_seen", seen, 1);
        if (seen) begin
            if (poke) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end else begin
            wq.delete();
            dq.delete();
        end
        @(negedge clk);
        check_output("idle_busy", busy, 0);
        check_output("idle_wr_en", wr_en, 0);
        check_output("queues_drained", wq.size() + dq.size(), 0);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; mon_en = 1'b0;
        start = 1'b0; op_i = 2'b00; nwords_i = 2'b00; flag_load = 1'b0; flag_in = 4'h0;
        mflags = 4'h0; last_res = '0; last_flags = 4'h0;
        for (int i = 0; i < 4; i++) begin a_w[i] = 16'h0; b_w[i] = 16'h0; res_acc[i] = 16'h0; end

        reset = 1'b1;
        #2 reset = 1'b0;
        #2;
        check_output("rst_sci", sci, 0);
        check_output("rst_alu_sub", alu_sub, 0);
        check_output("rst_word_idx", word_idx, 0);
        check_output("rst_wr_en", wr_en, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_flags", {flag_c, flag_z, flag_s, flag_v}, 0);
        #8 reset = 1'b1;
        mon_en = 1'b1;

        // ADD over two words with carry out of the low word.
        a_w[0] = 16'hFFFF; a_w[1] = 16'h0001; b_w[0] = 16'h0001; b_w[1] = 16'h0000;
        apply_stimulus(2'b00, 1, 1'b0, 4'h0, 1'b0);
        check_output("add2_result", last_res, 80'h20000);
        check_output("add2_czs", last_flags[3:1], 3'b000);

        // SUB of equal single words.
        a_w[0] = 16'h1234; b_w[0] = 16'h1234;
        apply_stimulus(2'b01, 0, 1'b0, 4'h0, 1'b0);
        check_output("sub_result", last_res, 80'h0);
        check_output("sub_cz", last_flags[3:2], 2'b11);

        // ADC with C loaded in the same cycle as start.
        a_w[0] = 16'h0000; b_w[0] = 16'h0000;
        apply_stimulus(2'b10, 0, 1'b1, 4'b1000, 1'b0);
        check_output("adc_result", last_res, 80'h1);
        check_output("adc_cz", last_flags[3:2], 2'b00);

        // Four-word ADD, low word sums to zero; start/flag_load pokes ignored.
        a_w[0] = 16'h8000; a_w[1] = 16'h0000; a_w[2] = 16'h0000; a_w[3] = 16'h0001;
        b_w[0] = 16'h8000; b_w[1] = 16'h0000; b_w[2] = 16'h0000; b_w[3] = 16'h0000;
        apply_stimulus(2'b00, 3, 1'b0, 4'h0, 1'b1);
        check_output("add4_result", last_res, 80'h0001_0000_0001_0000);
        check_output("add4_z", last_flags[2], 1'b0);

        // Flag load in IDLE, then reset in the middle of a 4-word ADD.
        @(posedge clk); #1;
        flag_load = 1'b1; flag_in = 4'b1111;
        @(posedge clk); #1;
        flag_load = 1'b0;
        @(negedge clk);
        check_output("idle_load", {flag_c, flag_z, flag_s, flag_v}, 4'b1111);
        mon_en = 1'b0;
        for (int i = 0; i < 4; i++) begin a_w[i] = 16'h4321; b_w[i] = 16'h1111; end
        @(posedge clk); #1;
        start = 1'b1; op_i = 2'b00; nwords_i = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("mid_exec_wr_en", wr_en, 1);
        #2 reset = 1'b0;
        #1;
        check_output("arst_sci", sci, 0);
        check_output("arst_alu_sub", alu_sub, 0);
        check_output("arst_word_idx", word_idx, 0);
        check_output("arst_wr_en", wr_en, 0);
        check_output("arst_busy", busy, 0);
        check_output("arst_done", done, 0);
        check_output("arst_flags", {flag_c, flag_z, flag_s, flag_v}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        wq.delete(); dq.delete();
        mflags = 4'h0;
        mon_en = 1'b1;

        // Start accepted normally after reset; signed overflow boundary.
        a_w[0] = 16'h7FFF; b_w[0] = 16'h0001;
        apply_stimulus(2'b00, 0, 1'b0, 4'h0, 1'b0);
        check_output("ovf_result", last_res, 80'h8000);
        check_output("ovf_flags", last_flags, 4'b0011);

        // Randomised requests.
        for (int t = 0; t < 60; t++) begin
            logic [1:0] ro;
            int         rn;
            logic       rl;
            ro = 2'($urandom_range(3, 0));
            rn = int'($urandom_range(3, 0));
            rl = ($urandom_range(3, 0) == 0);
            for (int i = 0; i < 4; i++) begin
                a_w[i] = 16'($urandom);
                b_w[i] = ($urandom_range(3, 0) == 0) ? a_w[i] : 16'($urandom);
            end
            apply_stimulus(ro, rn, rl, 4'($urandom), 1'($urandom_range(1, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
